// File: rtl/g711_stream_decoder.sv
// rtl/g711_stream_decoder.sv - two-stage G.711 A-law/mu-law to linear PCM expander with channel tags
`timescale 1ns/1ps
module g711_stream_decoder #(
    parameter int CHANNELS  = 2,
    parameter int OUT_WIDTH = 16,
    parameter int ALAW_XOR  = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_law,
    input  logic [CH_W-1:0]      in_chan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]      out_chan,
    output logic                 err_chan,
    input  logic                 err_clr,
    output logic [15:0]          sample_cnt
);

    localparam logic [CH_W:0] CHAN_LIMIT = (CH_W+1)'(CHANNELS);

    logic                        s1_valid;
    logic [7:0]                  s1_code;
    logic                        s1_law;
    logic [CH_W-1:0]             s1_chan;

    logic                        s2_free;
    logic                        in_fire;
    logic                        chan_bad;
    logic [7:0]                  code_in;

    logic [2:0]                  seg;
    logic [3:0]                  mant;
    logic [12:0]                 a_mag;
    logic [12:0]                 a_v13;
    logic [15:0]                 mu_t;
    logic [13:0]                 mu_mag;
    logic signed [13:0]          v14;
    logic signed [OUT_WIDTH-1:0] v_wide;
    logic [OUT_WIDTH-1:0]        dec_data;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign chan_bad = ({1'b0, in_chan} >= CHAN_LIMIT);

    // mu-law is stored inverted so bit 7 reads as "negative" and the magnitude bits read straight
    always_comb begin
        code_in = in_data;
        if (in_law) begin
            code_in = ~in_data;
        end else if (ALAW_XOR != 0) begin
            code_in = in_data ^ 8'h55;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= 8'd0;
            s1_law   <= 1'b0;
            s1_chan  <= '0;
        end else if (in_fire) begin
            s1_valid <= !chan_bad;
            s1_code  <= code_in;
            s1_law   <= in_law;
            s1_chan  <= in_chan;
        end else if (s1_valid && s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    always_comb begin
        seg  = s1_code[6:4];
        mant = s1_code[3:0];

        if (seg == 3'd0) begin
            a_mag = {8'd0, mant, 1'b1};
        end else begin
            a_mag = 13'({1'b1, mant, 1'b1}) << (seg - 3'd1);
        end
        a_v13 = s1_code[7] ? a_mag : -a_mag;

        // the mu-law formula lands on a 16-bit scale; dividing by 4 is exact since t-132 is a multiple of 4
        mu_t   = (16'({mant, 3'b000}) + 16'd132) << seg;
        mu_mag = 14'((mu_t - 16'd132) >> 2);

        if (s1_law) begin
            v14 = s1_code[7] ? -mu_mag : mu_mag;
        end else begin
            v14 = {a_v13, 1'b0};
        end

        v_wide   = OUT_WIDTH'(v14);
        dec_data = v_wide <<< (OUT_WIDTH - 14);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= dec_data;
                out_chan <= s1_chan;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

    // a fresh bad beat outranks a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_chan <= 1'b0;
        end else if (in_fire && chan_bad) begin
            err_chan <= 1'b1;
        end else if (err_clr) begin
            err_chan <= 1'b0;
        end
    end

endmodule

// File: tb/tb_g711_stream_decoder.sv
// tb/tb_g711_stream_decoder.sv - scoreboard bench for g711_stream_decoder against an arithmetic G.711 model
`timescale 1ns/1ps
module tb_g711_stream_decoder;

    localparam int CHANNELS  = 3;
    localparam int OUT_WIDTH = 16;
    localparam int CH_W      = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [7:0]           in_data = 8'd0;
    logic                 in_law = 1'b0;
    logic [CH_W-1:0]      in_chan = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [OUT_WIDTH-1:0] out_data;
    logic [CH_W-1:0]      out_chan;
    logic                 err_chan;
    logic                 err_clr = 1'b0;
    logic [15:0]          sample_cnt;

    g711_stream_decoder #(
        .CHANNELS  (CHANNELS),
        .OUT_WIDTH (OUT_WIDTH),
        .ALAW_XOR  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_law     (in_law),
        .in_chan    (in_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .err_chan   (err_chan),
        .err_clr    (err_clr),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0] chan;
        logic [15:0]     data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ready_mode = 0;
    int   cycle = 0;
    int   good_beats = 0;

    always @(posedge clk) cycle++;

    // 0: always ready, 1: random 50%, 2: stalled
    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // G.711 expansion straight from the segment/mantissa definitions, scaled to 16 bits
    function automatic int ref_lin16(input logic [7:0] code, input logic law);
        logic [7:0] c;
        int seg, mant, mag, t;
        if (!law) begin
            c    = code ^ 8'h55;
            seg  = int'(c[6:4]);
            mant = int'(c[3:0]);
            mag  = (seg == 0) ? (2 * mant + 1) : (2 * mant + 33) * (1 << (seg - 1));
            return c[7] ? mag * 8 : -mag * 8;
        end
        c    = ~code;
        seg  = int'(c[6:4]);
        mant = int'(c[3:0]);
        t    = (8 * mant + 132) * (1 << seg);
        return c[7] ? 132 - t : t - 132;
    endfunction

    // monitor: pops expectations on every output handshake and checks stall stability
    logic            prev_stall = 1'b0;
    logic [15:0]     prev_data;
    logic [CH_W-1:0] prev_chan;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_chan", 32'(out_chan), 32'(prev_chan));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    flag("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_chan", 32'(out_chan), 32'(e.chan));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_chan  = out_chan;
        end
    end

    task automatic send(input logic [7:0] d, input logic law, input int chan, input int expect_data,
                        input logic clr);
        int waited = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_law   = law;
        in_chan  = CH_W'(chan);
        err_clr  = clr;
        #1;
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            flag("send_timeout");
            in_valid = 1'b0;
            return;
        end
        if (chan < CHANNELS) begin
            e.chan = CH_W'(chan);
            e.data = expect_data[15:0];
            sb.push_back(e);
            good_beats++;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic send_rand(input int max_chan);
        logic [7:0] d;
        logic       law;
        d   = 8'($urandom);
        law = 1'($urandom_range(0, 1));
        send(d, law, int'($urandom_range(0, max_chan)), ref_lin16(d, law), 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < 500) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (sb.size() != 0 || out_valid) flag("drain_timeout");
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        check("rst_err_chan", 32'(err_chan), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        sb.delete();
        good_beats = 0;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int start;

        repeat (3) @(negedge clk);
        #1;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out_data", 32'(out_data), 32'd0);
        check("init_out_chan", 32'(out_chan), 32'd0);
        check("init_err_chan", 32'(err_chan), 32'd0);
        check("init_sample_cnt", 32'(sample_cnt), 32'd0);
        check("init_in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;

        // A-law table values, with a latency probe on the first beat
        send(8'hD5, 1'b0, 0, 32'h0008, 1'b0);
        idle();
        #1;
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_edge2_valid", 32'(out_valid), 32'd1);
        check("lat_edge2_data", 32'(out_data), 32'h0008);
        send(8'h55, 1'b0, 1, 32'hFFF8, 1'b0);
        send(8'hAA, 1'b0, 2, 32'h7E00, 1'b0);
        send(8'h2A, 1'b0, 0, 32'h8200, 1'b0);
        send(8'hFF, 1'b1, 1, 32'h0000, 1'b0);
        send(8'h80, 1'b1, 2, 32'h7D7C, 1'b0);
        send(8'h00, 1'b1, 0, 32'h8284, 1'b0);
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send(d, 1'(i % 2), int'($urandom_range(0, 2)), ref_lin16(d, 1'(i % 2)), 1'b0);
        end
        idle();
        drain();
        check("cnt_directed", 32'(sample_cnt), 32'd31);

        // backpressure: ten beats under random out_ready
        pulse_reset();
        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            send_rand(2);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        drain();
        check("cnt_backpressure", 32'(sample_cnt), 32'd10);

        // mixed stream including out-of-range tags
        for (int i = 0; i < 60; i++) send_rand(3);
        idle();
        drain();
        check("cnt_mixed", 32'(sample_cnt), 32'(good_beats));
        ready_mode = 0;

        // channel range errors and clear priority
        pulse_reset();
        send(8'hD5, 1'b0, 0, 32'h0008, 1'b0);
        idle();
        #1;
        check("err_before_bad", 32'(err_chan), 32'd0);
        send(8'h12, 1'b0, 3, 0, 1'b0);
        idle();
        #1;
        check("err_after_bad", 32'(err_chan), 32'd1);
        send(8'h55, 1'b0, 1, 32'hFFF8, 1'b0);
        idle();
        drain();
        check("cnt_chan_drop", 32'(sample_cnt), 32'd2);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("err_cleared", 32'(err_chan), 32'd0);
        send(8'h34, 1'b1, 3, 0, 1'b1);
        idle();
        #1;
        check("err_set_wins", 32'(err_chan), 32'd1);
        drain();
        check("cnt_after_clr", 32'(sample_cnt), 32'd2);

        // reset with two beats parked in the pipeline
        ready_mode = 2;
        send(8'hAA, 1'b0, 0, 32'h7E00, 1'b0);
        send(8'h80, 1'b1, 1, 32'h7D7C, 1'b0);
        idle();
        #1;
        check("inflight_valid", 32'(out_valid), 32'd1);
        check("inflight_in_ready", 32'(in_ready), 32'd0);
        pulse_reset();
        ready_mode = 0;
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_cnt", 32'(sample_cnt), 32'd0);

        // counter wrap at full throughput
        pulse_reset();
        send_rand(2);
        start = cycle;
        for (int i = 1; i < 65537; i++) send_rand(2);
        check("no_bubble_cycles", 32'(cycle - start), 32'd65536);
        idle();
        drain();
        check("cnt_wrap", 32'(sample_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
